// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment scan driver with a prescaled
// slot clock, a tear-free load handshake that commits at frame boundaries and
// per-digit PWM brightness.
// Optional feature macro: SEG_LZB_EN (leading-zero blanking).
module seg_scan_driver #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned DIV_BITS    = 13,
  parameter int unsigned BRIGHT_BITS = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     LOAD,
  input  logic [4*DIGITS-1:0]      VALUE,
  input  logic [BRIGHT_BITS-1:0]   BRIGHT,
  output logic                     READY,
  output logic                     FRAME,
  output logic [DIGITS-1:0]        DS_EN,
  output logic [6:0]               DS_SEG
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  logic [DIV_BITS-1:0] r_presc;
  logic [IdxW-1:0]     r_idx;
  logic [4*DIGITS-1:0] r_pend;
  logic [4*DIGITS-1:0] r_disp;
  logic                r_ready;
  logic                r_frame;
  logic [DIGITS-1:0]   r_ds_en;
  logic [6:0]          r_ds_seg;

  logic                w_tick;
  logic                w_wrap;
  logic                w_duty_on;
  logic                w_blank;
  logic [3:0]          w_nib;
  logic [6:0]          w_dec;
  logic [DIGITS-1:0]   w_en_n;
  logic [6:0]          w_seg;

  assign w_tick    = &r_presc;
  assign w_wrap    = w_tick && (r_idx == LastIdx);
  assign w_duty_on = r_presc[DIV_BITS-1 -: BRIGHT_BITS] < BRIGHT;
  assign w_nib     = r_disp[4*r_idx +: 4];

  // Prescaler and slot index; idx wraps to 0 at the frame boundary.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == LastIdx) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Load handshake: capture into pend while ready, commit to disp at frame boundary.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pend  <= '0;
      r_disp  <= '0;
      r_ready <= 1'b1;
    end else if (LOAD && r_ready) begin
      r_pend  <= VALUE;
      r_ready <= 1'b0;
    end else if (w_wrap && !r_ready) begin
      r_disp  <= r_pend;
      r_ready <= 1'b1;
    end
  end

`ifdef SEG_LZB_EN
  logic [IdxW-1:0] w_msnz;

  // Index of the most significant nonzero nibble of disp (0 if all zero).
  always_comb begin
    w_msnz = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_disp[4*k +: 4] != 4'h0) begin
        w_msnz = IdxW'(k);
      end
    end
  end

  // Digit 0 can never satisfy idx > msnz, so a zero value still shows one "0".
  assign w_blank = r_idx > w_msnz;
`else
  assign w_blank = 1'b0;
`endif

  // Hex to segment decode, bit order {A,B,C,D,E,F,G}.
  always_comb begin
    w_dec = 7'b0000000;
    unique case (w_nib)
      4'h0: w_dec = 7'b1111110;
      4'h1: w_dec = 7'b0110000;
      4'h2: w_dec = 7'b1101101;
      4'h3: w_dec = 7'b1111001;
      4'h4: w_dec = 7'b0110011;
      4'h5: w_dec = 7'b1011011;
      4'h6: w_dec = 7'b1011111;
      4'h7: w_dec = 7'b1110000;
      4'h8: w_dec = 7'b1111111;
      4'h9: w_dec = 7'b1111011;
      4'hA: w_dec = 7'b1110111;
      4'hB: w_dec = 7'b0011111;
      4'hC: w_dec = 7'b1001110;
      4'hD: w_dec = 7'b0111101;
      4'hE: w_dec = 7'b1001111;
      4'hF: w_dec = 7'b1000111;
      default: w_dec = 7'b0000000;
    endcase
  end

  // Next output values: enable current slot digit only inside the PWM on-window.
  always_comb begin
    w_en_n = '1;
    w_seg  = 7'b0000000;
    if (w_duty_on && !w_blank) begin
      w_en_n[r_idx] = 1'b0;
      w_seg         = w_dec;
    end
  end

  // Registered pin outputs and frame pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_frame  <= 1'b0;
      r_ds_en  <= '1;
      r_ds_seg <= '0;
    end else begin
      r_frame  <= w_wrap;
      r_ds_en  <= w_en_n;
      r_ds_seg <= w_seg;
    end
  end

  assign READY  = r_ready;
  assign FRAME  = r_frame;
  assign DS_EN  = r_ds_en;
  assign DS_SEG = r_ds_seg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (4 digits, 16-cycle slots).
// Expected values follow SEG_LZB_EN when the bench is built with it defined.
module tb_seg_scan_driver;

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned DIV_BITS    = 4;
  localparam int unsigned BRIGHT_BITS = 2;
`ifdef SEG_LZB_EN
  localparam bit Lzb = 1'b1;
`else
  localparam bit Lzb = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LOAD = 1'b0;
  logic [15:0] VALUE = 16'h0;
  logic [1:0]  BRIGHT = 2'd3;
  logic        READY;
  logic        FRAME;
  logic [3:0]  DS_EN;
  logic [6:0]  DS_SEG;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(
    .DIGITS      (DIGITS),
    .DIV_BITS    (DIV_BITS),
    .BRIGHT_BITS (BRIGHT_BITS)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .LOAD   (LOAD),
    .VALUE  (VALUE),
    .BRIGHT (BRIGHT),
    .READY  (READY),
    .FRAME  (FRAME),
    .DS_EN  (DS_EN),
    .DS_SEG (DS_SEG)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
          7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
          7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    return t[d];
  endfunction

  // Expected {DS_EN, DS_SEG} for slot k, slot cycle c, displayed value v, brightness b.
  function automatic logic [10:0] exp_out(input int k, input int c, input logic [15:0] v,
                                          input logic [1:0] b);
    int  msnz;
    bit  duty;
    bit  blank;
    logic [3:0] en;
    msnz = 0;
    for (int j = 0; j < 4; j++) if (v[4*j +: 4] != 4'h0) msnz = j;
    duty  = (c / 4) < int'(b);
    blank = Lzb && (k > msnz);
    if (duty && !blank) begin
      en = 4'hF;
      en[k] = 1'b0;
      return {en, dec(v[4*k +: 4])};
    end
    return {4'hF, 7'b0000000};
  endfunction

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Steps until FRAME is seen high at a negedge; ok=0 if the budget runs out.
  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (FRAME === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    step();
    step();
    checks++; if (DS_EN !== 4'hF) begin errors++; $display("FAIL rst_en got %b exp 1111", DS_EN); end
    checks++; if (DS_SEG !== 7'h0) begin errors++; $display("FAIL rst_seg got %b exp 0", DS_SEG); end
    checks++; if (READY !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", READY); end
    checks++; if (FRAME !== 1'b0) begin errors++; $display("FAIL rst_frame got %b exp 0", FRAME); end
    RST = 1'b0;
    step();
    checks++;
    if ({DS_EN, DS_SEG} !== {4'b1110, 7'b1111110}) begin
      errors++; $display("FAIL rst_first_slot got %b_%b exp 1110_1111110", DS_EN, DS_SEG);
    end
    // Reset mid slot 2 with a load pending.
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_wait_frame got timeout exp FRAME"); end
    VALUE = 16'hABCD; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    checks++; if (READY !== 1'b0) begin errors++; $display("FAIL rst_pend_ready got %b exp 0", READY); end
    for (int i = 0; i < 36; i++) step();
    #2 RST = 1'b1;
    #1;
    checks++; if (DS_EN !== 4'hF) begin errors++; $display("FAIL rst_mid_en got %b exp 1111", DS_EN); end
    checks++; if (DS_SEG !== 7'h0) begin errors++; $display("FAIL rst_mid_seg got %b exp 0", DS_SEG); end
    checks++; if (READY !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", READY); end
    checks++; if (FRAME !== 1'b0) begin errors++; $display("FAIL rst_mid_frame got %b exp 0", FRAME); end
    @(negedge CLK);
    RST = 1'b0;
    step();
    checks++;
    if ({DS_EN, DS_SEG, READY} !== {4'b1110, 7'b1111110, 1'b1}) begin
      errors++; $display("FAIL rst_mid_restart got %b_%b_%b exp 1110_1111110_1", DS_EN, DS_SEG, READY);
    end
    // The discarded load must not commit at the next boundary.
    wait_frame(ok);
    step();
    checks++;
    if ({DS_EN, DS_SEG} !== {4'b1110, 7'b1111110}) begin
      errors++; $display("FAIL rst_discard got %b_%b exp 1110_1111110", DS_EN, DS_SEG);
    end
  endtask

  task automatic test_load_commit();
    bit ok;
    logic [10:0] e;
    VALUE = 16'h1234; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    checks++; if (READY !== 1'b0) begin errors++; $display("FAIL load_ready_low got %b exp 0", READY); end
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL load_wait_frame got timeout exp FRAME"); end
    checks++; if (READY !== 1'b1) begin errors++; $display("FAIL load_ready_high got %b exp 1", READY); end
    for (int n = 1; n <= 64; n++) begin
      step();
      e = exp_out((n - 1) / 16, (n - 1) % 16, 16'h1234, BRIGHT);
      checks++;
      if ({DS_EN, DS_SEG} !== e) begin
        errors++; $display("FAIL load_disp n=%0d got %b_%b exp %b_%b", n, DS_EN, DS_SEG, e[10:7], e[6:0]);
      end
    end
  endtask

  task automatic test_ignored_load();
    bit ok;
    logic [10:0] e;
    VALUE = 16'h5678; LOAD = 1'b1;
    step();
    checks++; if (READY !== 1'b0) begin errors++; $display("FAIL ign_ready got %b exp 0", READY); end
    // Held through the commit edge; must be ignored there too.
    VALUE = 16'hFFFF;
    wait_frame(ok);
    LOAD = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL ign_wait_frame got timeout exp FRAME"); end
    checks++; if (READY !== 1'b1) begin errors++; $display("FAIL ign_ready_commit got %b exp 1", READY); end
    for (int n = 1; n <= 64; n++) begin
      step();
      e = exp_out((n - 1) / 16, (n - 1) % 16, 16'h5678, BRIGHT);
      checks++;
      if ({DS_EN, DS_SEG} !== e) begin
        errors++; $display("FAIL ign_disp n=%0d got %b_%b exp %b_%b", n, DS_EN, DS_SEG, e[10:7], e[6:0]);
      end
    end
    checks++; if (READY !== 1'b1) begin errors++; $display("FAIL ign_no_queue got %b exp 1", READY); end
  endtask

  task automatic test_brightness();
    bit ok;
    logic [10:0] e;
    logic [1:0] bv [2];
    bv = '{2'd0, 2'd2};
    for (int t = 0; t < 2; t++) begin
      wait_frame(ok);
      checks++; if (!ok) begin errors++; $display("FAIL bright_wait_frame got timeout exp FRAME"); end
      BRIGHT = bv[t];
      for (int n = 1; n <= 64; n++) begin
        step();
        e = exp_out((n - 1) / 16, (n - 1) % 16, 16'h5678, bv[t]);
        checks++;
        if ({DS_EN, DS_SEG} !== e) begin
          errors++;
          $display("FAIL bright%0d n=%0d got %b_%b exp %b_%b", bv[t], n, DS_EN, DS_SEG, e[10:7], e[6:0]);
        end
      end
    end
    BRIGHT = 2'd3;
  endtask

  task automatic test_frame();
    bit ok;
    int cnt;
    int bad;
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL frame_wait got timeout exp FRAME"); end
    cnt = 0; bad = 0;
    for (int n = 1; n <= 192; n++) begin
      step();
      if (FRAME === 1'b1) begin
        cnt++;
        if (n % 64 != 0) bad++;
      end
    end
    checks++; if (cnt !== 3) begin errors++; $display("FAIL frame_count got %0d exp 3", cnt); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL frame_spacing got %0d off-period exp 0", bad); end
    checks++; if (FRAME !== 1'b1) begin errors++; $display("FAIL frame_at_192 got %b exp 1", FRAME); end
    #2 RST = 1'b1;
    #1;
    checks++; if (FRAME !== 1'b0) begin errors++; $display("FAIL frame_in_rst got %b exp 0", FRAME); end
    @(negedge CLK);
    checks++; if (FRAME !== 1'b0) begin errors++; $display("FAIL frame_held_rst got %b exp 0", FRAME); end
    RST = 1'b0;
  endtask

  task automatic test_blanking();
    bit ok;
    logic [10:0] e;
    logic [15:0] vals [2];
    vals = '{16'h0005, 16'h0000};
    for (int t = 0; t < 2; t++) begin
      VALUE = vals[t]; LOAD = 1'b1;
      step();
      LOAD = 1'b0;
      wait_frame(ok);
      checks++; if (!ok) begin errors++; $display("FAIL blank_wait_frame got timeout exp FRAME"); end
      for (int n = 1; n <= 64; n++) begin
        step();
        e = exp_out((n - 1) / 16, (n - 1) % 16, vals[t], BRIGHT);
        checks++;
        if ({DS_EN, DS_SEG} !== e) begin
          errors++;
          $display("FAIL blank_%h n=%0d got %b_%b exp %b_%b", vals[t], n, DS_EN, DS_SEG, e[10:7], e[6:0]);
        end
      end
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_load_commit();
    test_ignored_load();
    test_brightness();
    test_frame();
    test_blanking();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
